instr_fetch_queue: RTL and testbench
====================================

Name: instr_fetch_queue

Overview:
- Instruction fetch stage plus instruction queue, directly upstream of the instruction decoder.
- Issues one word-read at a time to the instruction memory port and buffers {pc, instr} pairs in a circular FIFO.
- Presents the FIFO head to the decoder with a valid/ready handshake.
- Handles redirects (branch/jump resolution) by flushing the queue and discarding any in-flight response.

Parameters:
IQ_DEPTH_LOG, 3, log2 of queue depth (depth = 8 entries)
RESET_PC, 32'h0, PC loaded on reset

Ports:
clk_in  input  1  clock, all state on rising edge
rst_in  input  1  reset, asynchronous, active-low
rdy_in  input  1  global run enable; 0 freezes all state
mem_req_valid  output  1  fetch request
mem_req_addr  output  32  word address of fetch (bits[1:0]=0)
mem_req_ready  input  1  memory accepts request this cycle
mem_resp_valid  input  1  single-cycle pulse, response data valid
mem_resp_data  input  32  fetched instruction word
instr_out  output  32  queue-head instruction, to decoder
pc_out  output  32  queue-head PC
pred_taken_out  output  1  queue-head prediction bit (see Optional Feature)
valid_out  output  1  queue non-empty
ready_in  input  1  decoder consumes head this cycle
jump_en  input  1  redirect pulse
jump_pc  input  32  redirect target; bits[1:0] ignored, forced 0

Behaviour:
- Reset (rst_in=0, async): pc=RESET_PC, head=tail=count=0, state=IDLE, mem_req_valid=0, valid_out=0, instr_out=0, pc_out=0, pred_taken_out=0.
- rdy_in=0: no register changes, mem_req_valid=0. Memory guarantees no mem_resp_valid while rdy_in=0.
- States:
  - IDLE: mem_req_valid=1 iff count<2^IQ_DEPTH_LOG and !jump_en. On mem_req_valid & mem_req_ready -> WAIT, latch req_pc=pc.
  - WAIT: mem_req_valid=0. On mem_resp_valid: enqueue {req_pc, mem_resp_data, pred} at tail, tail++, pc=next_pc, -> IDLE.
  - DISCARD: mem_req_valid=0. On mem_resp_valid: drop data, -> IDLE.
- Slot reservation: a request issues only when a free slot exists. With one outstanding request, an enqueue never meets a full queue.
- Next PC: req_pc+4, or the predicted target when STATIC_BP_EN is defined. 32-bit wrap: 32'hFFFFFFFC+4=0.
- Output side:
  - valid_out = (count!=0).
  - instr_out/pc_out/pred_taken_out are combinational from the head entry.
  - Dequeue when valid_out & ready_in: head++.
  - Simultaneous enqueue and dequeue: count unchanged.
- Pointers are IQ_DEPTH_LOG bits wide and wrap naturally.
- Redirect (jump_en=1) has priority over everything except reset:
  - head=tail=count=0, pc=jump_pc&~3; a same-cycle dequeue is discarded.
  - IDLE -> IDLE, no request that cycle. First request to the new pc issues the next cycle.
  - WAIT without response this cycle -> DISCARD.
  - WAIT with mem_resp_valid the same cycle -> response dropped, -> IDLE.
  - DISCARD stays DISCARD (jump pc updated) until the response arrives.
- Latency: IDLE request to head visible at valid_out = memory latency + 1 cycle (enqueue registered).
- Reset mid-WAIT: state returns to IDLE. The memory controller is reset by the same rst_in, so no stale response arrives.

Optional Feature:
STATIC_BP_EN
- Defined: on enqueue, the response word is pre-decoded for the next PC.
  - JAL (opcode 1101111): next_pc = req_pc + J-imm, pred=1.
  - B-type (opcode 1100011) with imm sign bit instr[31]=1 (backward): next_pc = req_pc + B-imm, pred=1.
  - Otherwise: req_pc+4, pred=0.
  - Immediates are sign-extended to 32 bits with bit0=0.
- Not defined: next_pc always req_pc+4, pred_taken_out tied 0, no pre-decode logic.

Test Plan:
- Reset, 1-cycle memory, ready_in=1 -> requests at 0x0,0x4,0x8…; pc_out sequence 0x0,0x4,0x8; valid_out first high 2 cycles after first request.
- ready_in=0, continuous memory -> exactly 8 entries queued, mem_req_valid stays 0 with count=8. One dequeue -> next request issues the following cycle.
- Request to 0x10 pending, jump_en with jump_pc=0x103 -> DISCARD; response 0x00000013 dropped; next request addr 0x100; valid_out=0 until it returns.
- jump_en in the same cycle as mem_resp_valid -> response not enqueued, count=0, next request addr=jump_pc.
- rdy_in=0 for 5 cycles mid-stream -> pointers, pc and outputs unchanged; resumes identically.
- STATIC_BP_EN, word 0xFE000EE3 (beq x0,x0,-4) at 0x20 -> pred_taken_out=1, next request 0x1C. Without the macro -> 0x24, pred 0.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Fetch stage plus circular instruction queue feeding the decoder; one outstanding memory read.
// Optional static branch prediction pre-decode is enabled by defining STATIC_BP_EN.
module instr_fetch_queue #(
    parameter int          IQ_DEPTH_LOG = 3,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        pred_taken_out,
    output logic        valid_out,
    input  logic        ready_in,
    input  logic        jump_en,
    input  logic [31:0] jump_pc
);
    localparam int DEPTH = 1 << IQ_DEPTH_LOG;
    localparam int CNT_W = IQ_DEPTH_LOG + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t                  state_q;
    logic [31:0]             pc_q, req_pc_q;
    logic [IQ_DEPTH_LOG-1:0] head_q, tail_q;
    logic [CNT_W-1:0]        count_q;
    logic [31:0]             pc_mem_q    [DEPTH];
    logic [31:0]             instr_mem_q [DEPTH];
    logic [31:0]             next_pc_d;
    logic                    full, fire, enq, deq;

    assign full          = (count_q == CNT_W'(DEPTH));
    assign valid_out     = (count_q != '0);
    assign mem_req_addr  = pc_q;
    // Request only with a free slot reserved, so the response can always be enqueued.
    assign mem_req_valid = rst_in && rdy_in && (state_q == IDLE) && !full && !jump_en;
    assign fire          = mem_req_valid && mem_req_ready;
    assign enq           = rdy_in && (state_q == WAIT) && mem_resp_valid && !jump_en;
    assign deq           = rdy_in && valid_out && ready_in && !jump_en;
    assign instr_out     = instr_mem_q[head_q];
    assign pc_out        = pc_mem_q[head_q];

`ifdef STATIC_BP_EN
    logic        pred_mem_q [DEPTH];
    logic        pred_d;
    logic [31:0] j_imm, b_imm;

    assign j_imm = {{12{mem_resp_data[31]}}, mem_resp_data[19:12], mem_resp_data[20],
                    mem_resp_data[30:21], 1'b0};
    assign b_imm = {{20{mem_resp_data[31]}}, mem_resp_data[7], mem_resp_data[30:25],
                    mem_resp_data[11:8], 1'b0};
    assign pred_taken_out = pred_mem_q[head_q];

    always_comb begin
        next_pc_d = req_pc_q + 32'd4;
        pred_d    = 1'b0;
        if (mem_resp_data[6:0] == 7'b1101111) begin
            next_pc_d = req_pc_q + j_imm;
            pred_d    = 1'b1;
        end else if (mem_resp_data[6:0] == 7'b1100011 && mem_resp_data[31]) begin
            next_pc_d = req_pc_q + b_imm;
            pred_d    = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) pred_mem_q[i] <= 1'b0;
        end else if (enq) begin
            pred_mem_q[tail_q] <= pred_d;
        end
    end
`else
    assign pred_taken_out = 1'b0;
    assign next_pc_d      = req_pc_q + 32'd4;
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else if (rdy_in) begin
            if (jump_en) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
                pc_q    <= jump_pc & 32'hFFFF_FFFC;
                // An outstanding read must still be absorbed before the next request.
                if (state_q != IDLE)
                    state_q <= mem_resp_valid ? IDLE : DISCARD;
            end else begin
                case (state_q)
                    IDLE: if (fire) begin
                        req_pc_q <= pc_q;
                        state_q  <= WAIT;
                    end
                    WAIT: if (mem_resp_valid) begin
                        pc_mem_q[tail_q]    <= req_pc_q;
                        instr_mem_q[tail_q] <= mem_resp_data;
                        tail_q              <= tail_q + 1'b1;
                        pc_q                <= next_pc_d;
                        state_q             <= IDLE;
                    end
                    DISCARD: if (mem_resp_valid) state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
                if (deq) head_q <= head_q + 1'b1;
                count_q <= count_q + CNT_W'(enq) - CNT_W'(deq);
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: memory model plus {pc,instr,pred} scoreboard.
// Expected prediction behaviour follows whether STATIC_BP_EN is defined.
module tb_instr_fetch_queue;
    logic        clk_in = 0, rst_in = 0, rdy_in = 0;
    logic        mem_req_valid, mem_req_ready = 0, mem_resp_valid = 0;
    logic [31:0] mem_req_addr, mem_resp_data = 0;
    logic [31:0] instr_out, pc_out;
    logic        pred_taken_out, valid_out, ready_in = 0, jump_en = 0;
    logic [31:0] jump_pc = 0;

    instr_fetch_queue dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .instr_out(instr_out), .pc_out(pc_out),
        .pred_taken_out(pred_taken_out), .valid_out(valid_out), .ready_in(ready_in),
        .jump_en(jump_en), .jump_pc(jump_pc)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred;
    } sb_t;

    sb_t         sb[$];
    int          n_vec = 0, n_err = 0;
    int          mem_lat = 1, resp_cnt = 0, ncyc;
    logic        last_fire = 0, drop_pend = 0;
    logic [31:0] last_addr = 0, pend_addr = 0, pend_data = 0, exp_pc = 0;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        if (a == 32'h10) return 32'h0000_0013;
        if (a == 32'h20) return 32'hFE00_0EE3;
        return {a[23:0], 8'h13};
    endfunction

    // Only the one branch word used here is predicted; the rest are addi-type.
    function automatic logic bp_pred(input logic [31:0] instr);
`ifdef STATIC_BP_EN
        return instr == 32'hFE00_0EE3;
`else
        return instr == 32'h1 && instr == 32'h2;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_head();
        check("valid_out", {31'b0, valid_out}, {31'b0, sb.size() != 0});
        if (sb.size() != 0) begin
            check("pc_out", pc_out, sb[0].pc);
            check("instr_out", instr_out, sb[0].instr);
            check("pred_taken_out", {31'b0, pred_taken_out}, {31'b0, sb[0].pred});
        end
    endtask

    task automatic cycle();
        logic fire, jmp, resp, deq;
        logic [31:0] fa;
        sb_t e;
        mem_resp_valid = (resp_cnt == 1) && rdy_in;
        mem_resp_data  = pend_data;
        #1;
        check_head();
        fire = mem_req_valid && mem_req_ready;
        fa   = mem_req_addr;
        jmp  = jump_en && rdy_in;
        resp = mem_resp_valid;
        deq  = valid_out && ready_in && rdy_in && !jump_en;
        if (!rdy_in) check("stall_req", {31'b0, mem_req_valid}, 32'h0);
        if (fire) check("req_addr", fa, exp_pc);
        if (deq && sb.size() != 0) void'(sb.pop_front());
        if (resp) begin
            if (jmp || drop_pend) drop_pend = 0;
            else begin
                e.pc = pend_addr; e.instr = pend_data; e.pred = bp_pred(pend_data);
                sb.push_back(e);
                exp_pc = e.pred ? pend_addr - 32'd4 : pend_addr + 32'd4;
            end
        end
        if (jmp) begin
            sb.delete();
            exp_pc = jump_pc & 32'hFFFF_FFFC;
            if (resp_cnt > 0 && !resp) drop_pend = 1;
        end
        @(posedge clk_in);
        #1;
        if (resp) resp_cnt = 0;
        else if (resp_cnt > 1 && rdy_in) resp_cnt--;
        if (fire) begin
            resp_cnt  = mem_lat;
            pend_addr = fa;
            pend_data = data_of(fa);
        end
        last_fire = fire;
        if (fire) last_addr = fa;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_fire(input int budget, output int n);
        n = 0;
        last_fire = 0;
        while (!last_fire && n < budget) begin
            cycle();
            n++;
        end
        check("fire_timeout", {31'b0, last_fire}, 32'h1);
    endtask

    task automatic jump(input logic [31:0] t);
        jump_en = 1; jump_pc = t;
        cycle();
        jump_en = 0;
    endtask

    initial begin
        // Reset values
        #2;
        check("rst_valid_out", {31'b0, valid_out}, 32'h0);
        check("rst_req_valid", {31'b0, mem_req_valid}, 32'h0);
        check("rst_pc_out", pc_out, 32'h0);
        check("rst_instr_out", instr_out, 32'h0);
        check("rst_pred", {31'b0, pred_taken_out}, 32'h0);
        @(posedge clk_in); #1;
        rst_in = 1; rdy_in = 1; mem_req_ready = 1; ready_in = 1;

        // Streaming fetch, 1-cycle memory
        cycle();
        check("first_fire", {31'b0, last_fire}, 32'h1);
        check("first_addr", last_addr, 32'h0);
        check("wait_no_valid", {31'b0, valid_out}, 32'h0);
        cycle();
        check("first_valid_lat", {31'b0, valid_out}, 32'h1);
        run(14);

        // Fill with decoder stalled, then free one slot
        ready_in = 0;
        run(40);
        check("full_entries", sb.size(), 32'd8);
        check("full_no_req", {31'b0, mem_req_valid}, 32'h0);
        ready_in = 1;
        cycle();
        ready_in = 0;
        check("req_after_deq", {31'b0, mem_req_valid}, 32'h1);
        ready_in = 1;
        run(30);

        // Global freeze mid-stream
        rdy_in = 0;
        run(5);
        rdy_in = 1;
        run(12);

        // Redirect while a read to 0x10 is outstanding
        jump(32'h10);
        mem_lat = 3;
        wait_fire(20, ncyc);
        check("pre_jump_addr", last_addr, 32'h10);
        jump(32'h103);
        wait_fire(20, ncyc);
        check("discard_cycles", ncyc, 32'd3);
        check("discard_next_addr", last_addr, 32'h100);
        mem_lat = 1;
        run(6);

        // Redirect in the same cycle as the response
        wait_fire(20, ncyc);
        jump(32'h200);
        check("jr_valid_out", {31'b0, valid_out}, 32'h0);
        wait_fire(20, ncyc);
        check("jr_cycles", ncyc, 32'd1);
        check("jr_addr", last_addr, 32'h200);
        run(4);

        // 32-bit PC wrap
        jump(32'hFFFF_FFFC);
        wait_fire(20, ncyc);
        check("wrap_addr0", last_addr, 32'hFFFF_FFFC);
        wait_fire(20, ncyc);
        check("wrap_addr1", last_addr, 32'h0);
        run(4);

        // Backward branch pre-decode
        ready_in = 0;
        jump(32'h20);
        wait_fire(20, ncyc);
        cycle();
`ifdef STATIC_BP_EN
        check("bp_pred", {31'b0, pred_taken_out}, 32'h1);
        wait_fire(20, ncyc);
        check("bp_next_addr", last_addr, 32'h1C);
`else
        check("bp_pred", {31'b0, pred_taken_out}, 32'h0);
        wait_fire(20, ncyc);
        check("bp_next_addr", last_addr, 32'h24);
`endif
        ready_in = 1;
        run(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
